sdram_device_model: RTL

SDRAM_DEVICE_MODEL -- requirements
Module: sdram_device_model

---
 rtl/sdram_device_model.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/sdram_device_model.sv
// Behavioural single-rank SDR SDRAM device: command decode, init sequencing,
// per-bank row state, byte-masked storage, CL2/CL3 read pipeline on a
// bidirectional DQ bus, registered illegal-command pulse and REF counter.
module sdram_device_model #(
  parameter int ROW_WIDTH    = 13,
  parameter int COL_WIDTH    = 9,
  parameter int BANK_WIDTH   = 2,
  parameter int MEM_ROW_BITS = 4,
  parameter int MEM_COL_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clock_enable,
  input  logic                  cs_n,
  input  logic                  ras_n,
  input  logic                  cas_n,
  input  logic                  we_n,
  input  logic [BANK_WIDTH-1:0] bank_addr,
  input  logic [12:0]           addr,
  inout  wire  [15:0]           data,
  input  logic                  data_mask_low,
  input  logic                  data_mask_high,
  output logic                  init_done,
  output logic                  cmd_error,
  output logic [15:0]           ref_count
);

  localparam int DATA_W    = 16;
  localparam int NUM_BANKS = 1 << BANK_WIDTH;
  localparam int MEM_AW    = BANK_WIDTH + MEM_ROW_BITS + MEM_COL_BITS;
  localparam int MEM_WORDS = 1 << MEM_AW;

  localparam logic [2:0] CMD_NOP   = 3'b111;
  localparam logic [2:0] CMD_ACT   = 3'b011;
  localparam logic [2:0] CMD_READ  = 3'b101;
  localparam logic [2:0] CMD_WRITE = 3'b100;
  localparam logic [2:0] CMD_PRE   = 3'b010;
  localparam logic [2:0] CMD_REF   = 3'b001;
  localparam logic [2:0] CMD_MRS   = 3'b000;

  typedef enum logic [2:0] {
    ST_WAIT_PALL,
    ST_WAIT_REF1,
    ST_WAIT_REF2,
    ST_WAIT_MRS,
    ST_READY
  } init_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  init_state_t             init_q, init_d;
  logic [1:0]              cl_q, cl_d;
  logic [15:0]             ref_count_q, ref_count_d;
  logic                    cmd_error_q, cmd_error_d;
  logic [NUM_BANKS-1:0]    bank_active_q;
  logic [ROW_WIDTH-1:0]    open_row_q [NUM_BANKS];
  logic [DATA_W-1:0]       mem [MEM_WORDS];

  logic [2:0]              cmd;
  logic [COL_WIDTH-1:0]    col;
  logic [MEM_AW-1:0]       mem_idx;
  logic [DATA_W-1:0]       mem_rd;
  logic                    mrs_legal;
  logic                    do_act, do_pre, do_wr, do_rd;
  logic                    unused_addr_bits;

  logic                    vld_p0, vld_p1, vld_p2;
  logic [DATA_W-1:0]       rd_data_p0, rd_data_p1, rd_data_p2;

  // Deselect or CKE low collapse to NOP; word index uses low row/col bits only.
  always_comb begin
    cmd       = (clock_enable && !cs_n) ? {ras_n, cas_n, we_n} : CMD_NOP;
    col       = addr[COL_WIDTH-1:0];
    mem_idx   = {bank_addr, open_row_q[bank_addr][MEM_ROW_BITS-1:0], col[MEM_COL_BITS-1:0]};
    mem_rd    = mem[mem_idx];
    mrs_legal = ((addr[6:4] == 3'd2) || (addr[6:4] == 3'd3)) && (addr[2:0] == 3'b000);
  end

  // Aliased row/column bits are kept for fidelity but never index storage.
  always_comb begin
    unused_addr_bits = ^col[COL_WIDTH-1:MEM_COL_BITS];
    for (int b = 0; b < NUM_BANKS; b++) begin
      unused_addr_bits = unused_addr_bits ^ (^open_row_q[b][ROW_WIDTH-1:MEM_ROW_BITS]);
    end
  end

  // Command legality, init sequencing, CL and REF counter next state.
  always_comb begin
    init_d      = init_q;
    cl_d        = cl_q;
    ref_count_d = ref_count_q;
    cmd_error_d = 1'b0;
    do_act      = 1'b0;
    do_pre      = 1'b0;
    do_wr       = 1'b0;
    do_rd       = 1'b0;
    case (cmd)
      CMD_NOP: ;
      CMD_ACT: begin
        if (init_q != ST_READY || bank_active_q[bank_addr]) cmd_error_d = 1'b1;
        else                                                 do_act      = 1'b1;
      end
      CMD_READ: begin
        if (init_q != ST_READY || !bank_active_q[bank_addr]) cmd_error_d = 1'b1;
        else                                                  do_rd       = 1'b1;
      end
      CMD_WRITE: begin
        if (init_q != ST_READY || !bank_active_q[bank_addr]) cmd_error_d = 1'b1;
        else                                                  do_wr       = 1'b1;
      end
      CMD_PRE: begin
        if (init_q == ST_WAIT_PALL && addr[10]) init_d      = ST_WAIT_REF1;
        else if (init_q == ST_READY)            do_pre      = 1'b1;
        else                                    cmd_error_d = 1'b1;
      end
      CMD_REF: begin
        case (init_q)
          ST_WAIT_REF1: begin
            init_d      = ST_WAIT_REF2;
            ref_count_d = sat_inc16(ref_count_q);
          end
          ST_WAIT_REF2: begin
            init_d      = ST_WAIT_MRS;
            ref_count_d = sat_inc16(ref_count_q);
          end
          ST_READY: begin
            if (|bank_active_q) cmd_error_d = 1'b1;
            else                ref_count_d = sat_inc16(ref_count_q);
          end
          default: cmd_error_d = 1'b1;
        endcase
      end
      CMD_MRS: begin
        if ((init_q == ST_WAIT_MRS || init_q == ST_READY) && mrs_legal) begin
          cl_d = addr[5:4];
          if (init_q == ST_WAIT_MRS) init_d = ST_READY;
        end else begin
          cmd_error_d = 1'b1;
        end
      end
      default: cmd_error_d = 1'b1;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      init_q      <= ST_WAIT_PALL;
      cl_q        <= 2'd3;
      ref_count_q <= '0;
      cmd_error_q <= 1'b0;
    end else begin
      init_q      <= init_d;
      cl_q        <= cl_d;
      ref_count_q <= ref_count_d;
      cmd_error_q <= cmd_error_d;
    end
  end

  // Per-bank active flag and open row; open row only matters while active.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_active_q <= '0;
    end else begin
      if (do_act) begin
        bank_active_q[bank_addr] <= 1'b1;
        open_row_q[bank_addr]    <= addr[ROW_WIDTH-1:0];
      end
      if (do_pre) begin
        if (addr[10]) bank_active_q            <= '0;
        else          bank_active_q[bank_addr] <= 1'b0;
      end
    end
  end

  // Byte-masked storage write; contents survive reset.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      if (!data_mask_low)  mem[mem_idx][7:0]  <= data[7:0];
      if (!data_mask_high) mem[mem_idx][15:8] <= data[15:8];
    end
  end

  // Read pipeline valids. CL3 enters at p0, CL2 at p1; p2 drives DQ, so the
  // word is on the bus during the cycle that ends on edge N+CL.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p0 <= do_rd && (cl_q == 2'd3);
      vld_p1 <= vld_p0 || (do_rd && (cl_q == 2'd2));
      vld_p2 <= vld_p1;
    end
  end

  // Read pipeline data, fetched from storage on the command edge.
  always_ff @(posedge clk) begin
    // stage p0: CL3 entry
    rd_data_p0 <= mem_rd;
    // stage p1: CL2 entry or shift from p0
    rd_data_p1 <= (do_rd && (cl_q == 2'd2)) ? mem_rd : rd_data_p0;
    // stage p2: bus driver
    rd_data_p2 <= rd_data_p1;
  end

  assign data      = vld_p2 ? rd_data_p2 : {DATA_W{1'bz}};
  assign init_done = (init_q == ST_READY);
  assign cmd_error = cmd_error_q;
  assign ref_count = ref_count_q;

endmodule
